// File: rtl/branch_predict_if.sv
// branch_predict_if: decode/execute signal bundle between the pipeline and the direction predictor
interface branch_predict_if #(parameter int PHT_INDEX_W = 10, parameter int GHR_W = 8);
  logic [31:0]            pcD;
  logic                   branchD;
  logic                   stallD;
  logic                   flushD;
  logic                   pred_takeD;
  logic [PHT_INDEX_W-1:0] pht_indexD;
  logic [GHR_W-1:0]       ghr_snapD;
  logic                   update_validE;
  logic                   actual_takeE;
  logic                   pred_takeE;
  logic [PHT_INDEX_W-1:0] pht_indexE;
  logic [GHR_W-1:0]       ghr_snapE;
  logic                   mispredictE;
  logic                   init_done;
  modport master (
    output pcD, branchD, stallD, flushD, update_validE, actual_takeE, pred_takeE, pht_indexE, ghr_snapE,
    input  pred_takeD, pht_indexD, ghr_snapD, mispredictE, init_done
  );
  modport slave (
    input  pcD, branchD, stallD, flushD, update_validE, actual_takeE, pred_takeE, pht_indexE, ghr_snapE,
    output pred_takeD, pht_indexD, ghr_snapD, mispredictE, init_done
  );
endinterface

// File: rtl/branch_predict.sv
// branch_predict: gshare direction predictor with speculative global history and mispredict recovery
module branch_predict #(
  parameter int PHT_INDEX_W = 10,
  parameter int GHR_W       = 8
) (
  input logic             clk,
  input logic             rst,
  branch_predict_if.slave bp
);
  typedef enum logic {INIT, RUN} state_t;
  state_t                 state, state_n;
  logic [1:0]             pht [2**PHT_INDEX_W];
  logic [PHT_INDEX_W-1:0] init_ptr, idx;
  logic [GHR_W-1:0]       spec_ghr;
  logic [1:0]             cnt, cnt_n;
  always_comb begin
    state_n = state;
    state_n = (state == INIT && &init_ptr) ? RUN : state;
  end
  assign idx            = bp.pcD[PHT_INDEX_W+1:2] ^ PHT_INDEX_W'(spec_ghr);
  assign bp.pht_indexD  = idx;
  assign bp.ghr_snapD   = spec_ghr;
  assign bp.init_done   = state == RUN;
  assign bp.pred_takeD  = bp.init_done & bp.branchD & pht[idx][1];
  assign bp.mispredictE = bp.update_validE & (bp.pred_takeE ^ bp.actual_takeE);
  assign cnt            = pht[bp.pht_indexE];
  assign cnt_n          = bp.actual_takeE ? (&cnt ? cnt : cnt + 2'd1) : (|cnt ? cnt - 2'd1 : cnt);
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      init_ptr <= '0;
    end else begin
      state <= state_n;
      if (state == INIT) init_ptr <= init_ptr + PHT_INDEX_W'(1);
    end
  end
  // The table itself is never reset; the INIT sweep rewrites every entry instead.
  always_ff @(posedge clk) begin
    if (!rst && state == INIT) pht[init_ptr] <= 2'b01;
    else if (!rst && bp.init_done && bp.update_validE) pht[bp.pht_indexE] <= cnt_n;
  end
  // Mispredict recovery outranks the decode shift, which belongs to a wrong-path instruction.
  always_ff @(posedge clk) begin
    if (rst) spec_ghr <= '0;
    else if (bp.mispredictE) spec_ghr <= {bp.ghr_snapE[GHR_W-2:0], bp.actual_takeE};
    else if (bp.branchD & ~bp.stallD & ~bp.flushD & bp.init_done) spec_ghr <= {spec_ghr[GHR_W-2:0], bp.pred_takeD};
  end
endmodule

// File: tb/tb_branch_predict.sv
// tb_branch_predict: directed test-plan steps plus random traffic checked against a behavioural model
module tb_branch_predict;
  localparam int PW = 10;
  localparam int GW = 8;
  localparam int N  = 1 << PW;
  localparam int GMASK = (1 << GW) - 1;
  logic clk = 0;
  logic rst = 1;
  branch_predict_if #(.PHT_INDEX_W(PW), .GHR_W(GW)) bif();
  branch_predict #(.PHT_INDEX_W(PW), .GHR_W(GW)) dut (.clk(clk), .rst(rst), .bp(bif));
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail  = 0;
  int m_pht [N];
  int m_ghr = 0;
  int m_cnt = 0;
  bit m_done = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int m_idx();
    return int'((bif.pcD >> 2) & 32'(N - 1)) ^ m_ghr;
  endfunction
  function automatic bit m_pred();
    return m_done && bif.branchD && m_pht[m_idx()] >= 2;
  endfunction
  function automatic bit m_mis();
    return bif.update_validE && (bif.pred_takeE != bif.actual_takeE);
  endfunction
  task automatic model_edge();
    bit p, mis, done;
    int k;
    p = m_pred();
    mis = m_mis();
    done = m_done;
    if (rst) begin
      m_ghr = 0;
      m_cnt = 0;
      m_done = 0;
      foreach (m_pht[i]) m_pht[i] = 1;
    end else begin
      if (!done) begin
        m_cnt++;
        if (m_cnt == N) m_done = 1;
      end else if (bif.update_validE) begin
        k = int'(bif.pht_indexE);
        m_pht[k] = bif.actual_takeE ? (m_pht[k] == 3 ? 3 : m_pht[k] + 1) : (m_pht[k] == 0 ? 0 : m_pht[k] - 1);
      end
      if (mis) m_ghr = ((int'(bif.ghr_snapE) << 1) | int'(bif.actual_takeE)) & GMASK;
      else if (bif.branchD && !bif.stallD && !bif.flushD && done) m_ghr = ((m_ghr << 1) | int'(p)) & GMASK;
    end
  endtask
  task automatic cyc(input string tag);
    #1;
    chk({tag, ".pred"}, 32'(bif.pred_takeD), 32'(m_pred()));
    chk({tag, ".idx"}, 32'(bif.pht_indexD), 32'(m_idx()));
    chk({tag, ".ghr"}, 32'(bif.ghr_snapD), 32'(m_ghr));
    chk({tag, ".init"}, 32'(bif.init_done), 32'(m_done));
    chk({tag, ".mis"}, 32'(bif.mispredictE), 32'(m_mis()));
    model_edge();
    @(posedge clk);
    #1;
  endtask
  task automatic upd(input bit t, input int k, input string tag);
    bif.update_validE = 1;
    bif.actual_takeE = t;
    bif.pred_takeE = t;
    bif.pht_indexE = PW'(k);
    bif.ghr_snapE = '0;
    cyc(tag);
    bif.update_validE = 0;
  endtask
  task automatic mis_set(input bit act, input logic [GW-1:0] snap, input string tag);
    bif.update_validE = 1;
    bif.actual_takeE = act;
    bif.pred_takeE = ~act;
    bif.pht_indexE = '0;
    bif.ghr_snapE = snap;
    cyc(tag);
    bif.update_validE = 0;
  endtask
  initial begin
    bif.pcD = 32'h00400010;
    bif.branchD = 1;
    bif.stallD = 0;
    bif.flushD = 0;
    bif.update_validE = 0;
    bif.actual_takeE = 0;
    bif.pred_takeE = 0;
    bif.pht_indexE = '0;
    bif.ghr_snapE = '0;
    @(posedge clk);
    #1;
    model_edge();
    cyc("reset");
    rst = 0;
    for (int i = 0; i < N; i++) begin
      chk("init_low", 32'(bif.init_done), 32'd0);
      chk("init_pred", 32'(bif.pred_takeD), 32'd0);
      cyc("init");
    end
    chk("init_high", 32'(bif.init_done), 32'd1);
    chk("init_read01", 32'(bif.pred_takeD), 32'd0);
    chk("init_ghr", 32'(bif.ghr_snapD), 32'd0);
    bif.stallD = 1;
    upd(1, 4, "train_t1");
    chk("train_w_t", 32'(bif.pred_takeD), 32'd1);
    upd(1, 4, "train_t2");
    upd(1, 4, "train_t3");
    chk("train_s_t", 32'(bif.pred_takeD), 32'd1);
    upd(0, 4, "train_n1");
    chk("train_w_t2", 32'(bif.pred_takeD), 32'd1);
    upd(0, 4, "train_n2");
    upd(0, 4, "train_n3");
    chk("train_s_nt", 32'(bif.pred_takeD), 32'd0);
    for (int i = 0; i < 6; i++) upd(1, 4, "sat_t");
    chk("sat_hi", 32'(bif.pred_takeD), 32'd1);
    upd(0, 4, "sat_n_hi");
    chk("sat_hi_hold", 32'(bif.pred_takeD), 32'd1);
    for (int i = 0; i < 4; i++) upd(0, 4, "sat_n");
    upd(0, 4, "sat_n_extra");
    upd(1, 4, "sat_lo_probe");
    chk("sat_lo_hold", 32'(bif.pred_takeD), 32'd0);
    upd(1, 5, "prep5a");
    upd(1, 5, "prep5b");
    bif.stallD = 0;
    bif.update_validE = 1;
    bif.pred_takeE = 0;
    bif.actual_takeE = 1;
    bif.ghr_snapE = 8'h5A;
    #1;
    chk("mis_flag", 32'(bif.mispredictE), 32'd1);
    cyc("mis");
    bif.update_validE = 0;
    bif.stallD = 1;
    chk("mis_restore", 32'(bif.ghr_snapD), 32'hB5);
    mis_set(1, 8'h00, "ghr01");
    chk("stall_ghr0", 32'(bif.ghr_snapD), 32'h01);
    chk("stall_pred", 32'(bif.pred_takeD), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc("stall");
      chk("stall_hold", 32'(bif.ghr_snapD), 32'h01);
    end
    bif.stallD = 0;
    cyc("release");
    chk("release_shift", 32'(bif.ghr_snapD), 32'h03);
    bif.flushD = 1;
    cyc("flush");
    chk("flush_hold", 32'(bif.ghr_snapD), 32'h03);
    bif.flushD = 0;
    bif.stallD = 1;
    mis_set(0, 8'h00, "ghr00");
    upd(1, 4, "rtrain1");
    upd(1, 4, "rtrain2");
    chk("rtrain_pred", 32'(bif.pred_takeD), 32'd1);
    rst = 1;
    cyc("mid_rst");
    rst = 0;
    chk("mid_rst_ghr", 32'(bif.ghr_snapD), 32'd0);
    chk("mid_rst_init", 32'(bif.init_done), 32'd0);
    bif.stallD = 0;
    for (int i = 0; i < N; i++) cyc("reinit");
    chk("reinit_done", 32'(bif.init_done), 32'd1);
    chk("reinit_pred", 32'(bif.pred_takeD), 32'd0);
    for (int i = 0; i < 3000; i++) begin
      bif.pcD = 32'h00400000 | ($urandom_range(0, 7) << 2);
      bif.branchD = 1'($urandom_range(0, 3) != 0);
      bif.stallD = 1'($urandom_range(0, 3) == 0);
      bif.flushD = 1'($urandom_range(0, 7) == 0);
      bif.update_validE = 1'($urandom_range(0, 1));
      bif.actual_takeE = 1'($urandom_range(0, 1));
      bif.pred_takeE = 1'($urandom_range(0, 1));
      bif.pht_indexE = PW'($urandom_range(0, 15));
      bif.ghr_snapE = GW'($urandom_range(0, 255));
      cyc("rand");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_predict.md
# branch_predict

Gshare-style conditional-branch direction predictor, the counterpart to execute-stage branch resolution. Predicts taken/not-taken for the branch in decode. It is trained by the resolved outcome (`actual_takeE`) one stage later. It keeps a speculative global history register (GHR) and restores it from a per-branch snapshot on mispredict. It also flags the mispredict so the hazard unit can redirect fetch.

## Interface
Parameters:
- `PHT_INDEX_W`, 10: index width of the pattern history table (PHT); 2^10 = 1024 two-bit counters.
- `GHR_W`, 8: global history length; must satisfy 2 ≤ GHR_W ≤ PHT_INDEX_W.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `pcD`  in  32  PC of the instruction in decode.
- `branchD`  in  1  decode holds a conditional branch.
- `stallD`  in  1  decode stage held this cycle.
- `flushD`  in  1  decode instruction squashed this cycle.
- `pred_takeD`  out  1  predicted direction for the decode branch.
- `pht_indexD`  out  PHT_INDEX_W  PHT index used for this prediction; piped to E.
- `ghr_snapD`  out  GHR_W  speculative GHR before this branch's shift; piped to E.
- `update_validE`  in  1  E holds a valid branch advancing this cycle; exactly one pulse per branch.
- `actual_takeE`  in  1  resolved direction.
- `pred_takeE`  in  1  piped `pred_takeD`.
- `pht_indexE`  in  PHT_INDEX_W  piped `pht_indexD`.
- `ghr_snapE`  in  GHR_W  piped `ghr_snapD`.
- `mispredictE`  out  1  `update_validE & (pred_takeE != actual_takeE)`; combinational.
- `init_done`  out  1  PHT initialisation complete.

## Operation
- PHT entry: 2-bit saturating counter. 00 = strong NT, 01 = weak NT, 10 = weak T, 11 = strong T. Prediction = counter[1].
- Index: `pcD[PHT_INDEX_W+1:2] ^ {{(PHT_INDEX_W-GHR_W){1'b0}}, spec_ghr}`.
- Outputs from the index:
  - `pht_indexD` = the index.
  - `ghr_snapD` = `spec_ghr`.
  - `pred_takeD` = `init_done & branchD & PHT[index][1]`.
- FSM with two states, INIT and RUN.
  - INIT: write 01 to entry `init_ptr`, then increment `init_ptr`. After the write to entry 2^PHT_INDEX_W−1, go to RUN.
  - RUN: `init_done` = 1. No exit except reset.
- Counter update (RUN only, when `update_validE`):
  - Taken: increment `PHT[pht_indexE]`, saturating at 11.
  - Not taken: decrement it, saturating at 00.
  - In INIT, updates are dropped.
- Speculative GHR update, one of the following applies in priority order:
  1. `mispredictE`: `spec_ghr <= {ghr_snapE[GHR_W-2:0], actual_takeE}`. Any decode-stage shift in the same cycle is discarded, because that instruction is wrong-path.
  2. Else, if `branchD & ~stallD & ~flushD & init_done`: `spec_ghr <= {spec_ghr[GHR_W-2:0], pred_takeD}`.
  3. Else: hold.
- GHR shifts are allowed only when `init_done`. During INIT no branch may shift history; mispredict recovery still applies.
- Read-during-write to the same index: decode reads the old counter value, with no bypass. The new value is visible the next cycle.
- Reset: `spec_ghr` = 0, `init_ptr` = 0, state = INIT.
  - Outputs after reset: `init_done` = 0, `pred_takeD` = 0. `mispredictE` follows its inputs.
  - Reset mid-RUN restarts the full INIT sweep and discards all training.

## Timing
- Prediction: zero-latency combinational from `pcD`, `branchD` and `spec_ghr`.
- Training latency: a counter update or GHR change on edge N affects predictions from cycle N+1.
- INIT length:
  - Exactly 2^PHT_INDEX_W cycles after the cycle in which `rst` is sampled high.
  - With the defaults, `init_done` rises on the 1024th edge after `rst` deasserts.
  - `rst` held high keeps the FSM at `init_ptr` = 0.
- `mispredictE`: purely combinational, same cycle as `update_validE`.
- Stalls:
  - `stallD` holds history, so a stalled branch is shifted in once, on the cycle it leaves D.
  - E-side stalls are the caller's job: `update_validE` must be deasserted while E is stalled.
- Simultaneous `update_validE` (no mispredict) and a decode branch shift: both take effect on the same edge.

## Test plan
- Reset/INIT: pulse `rst` for 1 cycle, drive `branchD` = 1 throughout.
  - `init_done` = 0 and `pred_takeD` = 0 for 1024 cycles.
  - `init_done` = 1 from cycle 1024.
  - Every index then reads 01, so `pred_takeD` = 0.
- Training: GHR = 0, `pcD` = 0x00400010, so index = 0x004.
  - One taken update at index 0x004 → next cycle `pred_takeD` = 1 (counter 10).
  - Two more taken updates → counter 11.
  - One not-taken update → counter 10, `pred_takeD` still 1.
  - Two further not-taken updates → counter 00, `pred_takeD` = 0.
- Saturation: six taken updates on one index, then a read → 11. Five not-taken updates → 00, and a sixth not-taken leaves it at 00.
- Mispredict recovery: `update_validE` = 1, `pred_takeE` = 0, `actual_takeE` = 1, `ghr_snapE` = 8'h5A, with `branchD` = 1 in the same cycle.
  - `mispredictE` = 1 that cycle.
  - Next cycle `ghr_snapD` = 8'hB5; the decode shift is ignored.
- Stall/flush: `spec_ghr` = 8'h01, `branchD` = 1, `pred_takeD` = 1.
  - `stallD` = 1 for 3 cycles → GHR stays 8'h01.
  - Release → 8'h03.
  - A following branch with `flushD` = 1 → GHR stays 8'h03.
- Reset mid-operation: train index 0x004 to 11, then assert `rst` for 1 cycle.
  - GHR = 0, `init_done` = 0.
  - After 1024 cycles index 0x004 reads 01, so `pred_takeD` = 0.
